weight_az_multi: RTL

Parametrised successor to the single-gamma LPC bandwidth-expansion block. It computes ap[0]=a[0] and ap[i]=mult_r(a[i], gamma^i) for i=1..M. In dual mode it produces two weighted filters in one pass, for example A(z/gamma1) and A(z/gamma2) in the perceptual weighting path. Coefficient arithmetic runs on an internal saturating rounding multiplier, so no shared L_mult or L_add operators are required. The block is connected to the coefficient scratch memory through one read port and one write port.

---
 rtl/weight_az_pkg.sv | 30 +++
 rtl/weight_mult_r.sv | 42 ++++
 rtl/weight_az_multi.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/weight_az_pkg.sv
// Shared types and constants for the weighted-LPC (A(z/gamma)) block.
package weight_az_pkg;

  // Controller states. The encoding is exported on a debug port so
  // checkers can follow the sequencing without reaching into the design.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_RG1  = 4'd1,
    ST_RG2  = 4'd2,
    ST_RA0  = 4'd3,
    ST_CP1  = 4'd4,
    ST_CP2  = 4'd5,
    ST_RD   = 4'd6,
    ST_WR1  = 4'd7,
    ST_WR2  = 4'd8,
    ST_UF1  = 4'd9,
    ST_UF2  = 4'd10,
    ST_DONE = 4'd11
  } state_e;

  // Rounding constant added before taking the high half of a Q31 product.
  localparam logic [31:0] ROUND_C = 32'h0000_8000;

  // Saturation limits for the 16-bit and 32-bit fixed-point domains.
  localparam logic signed [15:0] MAX16 = 16'sh7FFF;
  localparam logic signed [15:0] MIN16 = 16'sh8000;
  localparam logic signed [31:0] MAX32 = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] MIN32 = 32'sh8000_0000;

endpackage

// File: rtl/weight_mult_r.sv
// Combinational Q15 x Q15 -> Q15 multiply with rounding and saturation:
// p = sat32(2*x*y), r = sat32(p + 0x8000), result = r[31:16].
module weight_mult_r
  import weight_az_pkg::*;
(
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  output logic [15:0] r_o
);

  logic signed [15:0] xs;
  logic signed [15:0] ys;
  logic signed [31:0] prod;
  logic signed [31:0] l_mult;
  logic        [32:0] sum;
  logic               unused_lsb;

  assign xs = x_i;
  assign ys = y_i;

  // Fractional multiply, doubled, then rounded into the upper half.
  always_comb begin
    prod = 32'(xs) * 32'(ys);
    // Only -1 * -1 overflows the doubled product.
    if (xs == MIN16 && ys == MIN16) begin
      l_mult = MAX32;
    end else begin
      l_mult = prod <<< 1;
    end
    // Sign-extended 33-bit sum; bits 32 and 31 disagree on overflow.
    sum = {l_mult[31], l_mult} + {1'b0, ROUND_C};
    if (sum[32] != sum[31]) begin
      r_o = sum[32] ? MIN16 : MAX16;
    end else begin
      r_o = sum[31:16];
    end
  end

  // The low half is discarded by the rounding step.
  assign unused_lsb = ^sum[15:0];

endmodule

// File: rtl/weight_az_multi.sv
// Bandwidth expansion of LPC coefficients: ap[0]=a[0], ap[i]=mult_r(a[i], gamma^i),
// optionally for two gammas in one pass. Talks to a scratch memory through
// one read port (data returns the cycle after the address) and one write port.
module weight_az_multi
  import weight_az_pkg::*;
#(
  parameter int M      = 10,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(M + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dual,
  input  logic [ADDR_W-1:0] A,
  input  logic [ADDR_W-1:0] AP1,
  input  logic [ADDR_W-1:0] AP2,
  input  logic [ADDR_W-1:0] gamma1Addr,
  input  logic [ADDR_W-1:0] gamma2Addr,
  output logic [ADDR_W-1:0] readAddr,
  input  logic [DATA_W-1:0] readIn,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0] writeOut,
  output logic              writeEn,
  output logic              busy,
  output logic              done,
  output logic [3:0]        dbg_state_o
);

  localparam int PAD_W = DATA_W - 16;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    i_q, i_d;
  logic                dual_q, dual_d;
  logic [ADDR_W-1:0]   a_base_q, a_base_d;
  logic [ADDR_W-1:0]   ap1_base_q, ap1_base_d;
  logic [ADDR_W-1:0]   ap2_base_q, ap2_base_d;
  logic [ADDR_W-1:0]   g1_addr_q, g1_addr_d;
  logic [ADDR_W-1:0]   g2_addr_q, g2_addr_d;
  logic [15:0]         g1_q, g1_d;
  logic [15:0]         g2_q, g2_d;
  logic [15:0]         fac1_q, fac1_d;
  logic [15:0]         fac2_q, fac2_d;
  logic [15:0]         areg_q, areg_d;
  logic [DATA_W-1:0]   a0_q, a0_d;

  // Shared multiplier; operands are chosen by state.
  logic [15:0]         mul_x;
  logic [15:0]         mul_y;
  logic [15:0]         mul_r;

  logic [ADDR_W-1:0]   i_off;
  logic                last_i;

  weight_mult_r u_mult (
    .x_i (mul_x),
    .y_i (mul_y),
    .r_o (mul_r)
  );

  assign i_off       = ADDR_W'(i_q);
  assign last_i      = (i_q == CNT_W'(M));
  assign dbg_state_o = state_q;

  // State, counter, latched bases and coefficient/factor registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      i_q        <= CNT_W'(1);
      dual_q     <= 1'b0;
      a_base_q   <= '0;
      ap1_base_q <= '0;
      ap2_base_q <= '0;
      g1_addr_q  <= '0;
      g2_addr_q  <= '0;
      g1_q       <= '0;
      g2_q       <= '0;
      fac1_q     <= '0;
      fac2_q     <= '0;
      areg_q     <= '0;
      a0_q       <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      dual_q     <= dual_d;
      a_base_q   <= a_base_d;
      ap1_base_q <= ap1_base_d;
      ap2_base_q <= ap2_base_d;
      g1_addr_q  <= g1_addr_d;
      g2_addr_q  <= g2_addr_d;
      g1_q       <= g1_d;
      g2_q       <= g2_d;
      fac1_q     <= fac1_d;
      fac2_q     <= fac2_d;
      areg_q     <= areg_d;
      a0_q       <= a0_d;
    end
  end

  // Next-state logic and per-state decode of the memory ports and multiplier.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    dual_d     = dual_q;
    a_base_d   = a_base_q;
    ap1_base_d = ap1_base_q;
    ap2_base_d = ap2_base_q;
    g1_addr_d  = g1_addr_q;
    g2_addr_d  = g2_addr_q;
    g1_d       = g1_q;
    g2_d       = g2_q;
    fac1_d     = fac1_q;
    fac2_d     = fac2_q;
    areg_d     = areg_q;
    a0_d       = a0_q;
    readAddr   = '0;
    writeAddr  = '0;
    writeOut   = '0;
    writeEn    = 1'b0;
    busy       = (state_q != ST_IDLE);
    done       = 1'b0;
    mul_x      = '0;
    mul_y      = '0;

    case (state_q)
      ST_IDLE: begin
        // Everything that defines the run is captured here and held.
        if (start) begin
          dual_d     = dual;
          a_base_d   = A;
          ap1_base_d = AP1;
          ap2_base_d = AP2;
          g1_addr_d  = gamma1Addr;
          g2_addr_d  = gamma2Addr;
          state_d    = ST_RG1;
        end
      end
      ST_RG1: begin
        readAddr = g1_addr_q;
        state_d  = dual_q ? ST_RG2 : ST_RA0;
      end
      ST_RG2: begin
        readAddr = g2_addr_q;
        g1_d     = readIn[15:0];
        fac1_d   = readIn[15:0];
        state_d  = ST_RA0;
      end
      ST_RA0: begin
        // The word arriving now is gamma2 in dual mode, gamma1 otherwise.
        readAddr = a_base_q;
        if (dual_q) begin
          g2_d   = readIn[15:0];
          fac2_d = readIn[15:0];
        end else begin
          g1_d   = readIn[15:0];
          fac1_d = readIn[15:0];
        end
        state_d = ST_CP1;
      end
      ST_CP1: begin
        // a[0] is copied as a full word.
        a0_d      = readIn;
        writeEn   = 1'b1;
        writeAddr = ap1_base_q;
        writeOut  = readIn;
        state_d   = dual_q ? ST_CP2 : ST_RD;
      end
      ST_CP2: begin
        writeEn   = 1'b1;
        writeAddr = ap2_base_q;
        writeOut  = a0_q;
        state_d   = ST_RD;
      end
      ST_RD: begin
        readAddr = a_base_q + i_off;
        state_d  = ST_WR1;
      end
      ST_WR1: begin
        // a[i] is kept in areg for the second filter's product.
        areg_d    = readIn[15:0];
        mul_x     = readIn[15:0];
        mul_y     = fac1_q;
        writeEn   = 1'b1;
        writeAddr = ap1_base_q + i_off;
        writeOut  = {{PAD_W{1'b0}}, mul_r};
        if (dual_q) begin
          state_d = ST_WR2;
        end else begin
          state_d = last_i ? ST_DONE : ST_UF1;
        end
      end
      ST_WR2: begin
        mul_x     = areg_q;
        mul_y     = fac2_q;
        writeEn   = 1'b1;
        writeAddr = ap2_base_q + i_off;
        writeOut  = {{PAD_W{1'b0}}, mul_r};
        state_d   = last_i ? ST_DONE : ST_UF1;
      end
      ST_UF1: begin
        // fac1 <- fac1 * gamma1, giving gamma1^(i+1) for the next coefficient.
        mul_x  = fac1_q;
        mul_y  = g1_q;
        fac1_d = mul_r;
        if (dual_q) begin
          state_d = ST_UF2;
        end else begin
          i_d     = i_q + CNT_W'(1);
          state_d = ST_RD;
        end
      end
      ST_UF2: begin
        mul_x   = fac2_q;
        mul_y   = g2_q;
        fac2_d  = mul_r;
        i_d     = i_q + CNT_W'(1);
        state_d = ST_RD;
      end
      ST_DONE: begin
        done    = 1'b1;
        i_d     = CNT_W'(1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
